// File: rtl/aligner_pkg.sv
// Shared types and geometry for the memory-stage data aligner.
package aligner_pkg;

  localparam int unsigned DA_N        = 32;
  localparam int unsigned DA_V        = 256;
  localparam int unsigned LINE_BYTES  = DA_V / 8;
  localparam int unsigned OFFSET_BITS = 5;
  localparam int unsigned LANE_BITS   = 3;
  localparam int unsigned CNT_W       = 3;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StIssue,
    StWait,
    StDone
  } da_state_t;

endpackage

// File: rtl/lane_mapper.sv
// Combinational width/shift rules: line address, lane select, byte enables,
// scalar replication for stores and scalar extraction for loads.
module lane_mapper
  import aligner_pkg::*;
#(
  parameter int unsigned N = DA_N,
  parameter int unsigned V = DA_V
) (
  input  logic [N-1:0]         i_addr,
  input  logic                 i_vec,
  input  logic [N-1:0]         i_wdata,
  input  logic [V-1:0]         i_wdata_v,
  input  logic [V-1:0]         i_rline,
  input  logic [LANE_BITS-1:0] i_rlane,
  output logic [LANE_BITS-1:0] o_lane,
  output logic [N-1:0]         o_line_addr,
  output logic [N-1:0]         o_byteena,
  output logic [V-1:0]         o_wline,
  output logic [N-1:0]         o_rscalar,
  output logic                 o_misalign
);

  logic [LANE_BITS-1:0] w_lane;
  logic [N-1:0]         w_lane_mask;

  assign w_lane      = i_addr[OFFSET_BITS-1:2];
  assign o_lane      = w_lane;
  assign o_line_addr = {{OFFSET_BITS{1'b0}}, i_addr[N-1:OFFSET_BITS]};

  // Four byte enables per 32-bit lane.
  assign w_lane_mask = {{(N-4){1'b0}}, 4'hF} << {w_lane, 2'b00};
  assign o_byteena   = i_vec ? '1 : w_lane_mask;

  assign o_wline    = i_vec ? i_wdata_v : {(V/N){i_wdata}};
  assign o_rscalar  = i_rline[i_rlane*N +: N];
  assign o_misalign = i_vec ? (|i_addr[OFFSET_BITS-1:0]) : (|i_addr[1:0]);

endmodule

// File: rtl/data_aligner.sv
// Memory-stage access unit: turns scalar/vector load/store requests into
// line accesses, aligns load data and stalls the pipeline while in flight.
module data_aligner
  import aligner_pkg::*;
#(
  parameter int unsigned N       = DA_N,
  parameter int unsigned V       = DA_V,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         MemtoRegM,
  input  logic         MemWriteM,
  input  logic         VecDataM,
  input  logic [N-1:0] ALUResultM,
  input  logic [N-1:0] WriteDataM,
  input  logic [V-1:0] WriteDataVM,
  input  logic [V-1:0] ReadData,
  output logic         RdenData,
  output logic         WrenData,
  output logic [N-1:0] AddressData,
  output logic [N-1:0] ByteenaData,
  output logic [V-1:0] WriteData,
  output logic [N-1:0] ReadDataM,
  output logic [V-1:0] ReadDataVM,
  output logic         BusyDA,
  output logic         MisalignM
);

  da_state_t            r_state;
  da_state_t            w_next_state;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_rden;
  logic                 r_wren;
  logic [N-1:0]         r_addr;
  logic [N-1:0]         r_byteena;
  logic [V-1:0]         r_wdata;
  logic                 r_misalign;
  logic                 r_vec;
  logic [LANE_BITS-1:0] r_lane;
  logic [N-1:0]         r_rdata_s;
  logic [V-1:0]         r_rdata_v;

  logic                 w_accept;
  logic                 w_busy;
  logic                 w_capture;
  logic [LANE_BITS-1:0] w_lane;
  logic [N-1:0]         w_line_addr;
  logic [N-1:0]         w_byteena;
  logic [V-1:0]         w_wline;
  logic [N-1:0]         w_rscalar;
  logic                 w_misalign;

  lane_mapper #(
    .N (N),
    .V (V)
  ) u_lane_mapper (
    .i_addr      (ALUResultM),
    .i_vec       (VecDataM),
    .i_wdata     (WriteDataM),
    .i_wdata_v   (WriteDataVM),
    .i_rline     (ReadData),
    .i_rlane     (r_lane),
    .o_lane      (w_lane),
    .o_line_addr (w_line_addr),
    .o_byteena   (w_byteena),
    .o_wline     (w_wline),
    .o_rscalar   (w_rscalar),
    .o_misalign  (w_misalign)
  );

  assign w_accept = (r_state == StIdle) & en & (MemtoRegM | MemWriteM);

  always_comb begin
    w_next_state = r_state;
    w_busy       = 1'b0;
    w_capture    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_busy       = 1'b1;
          // A simultaneous load+store request is treated as a store.
          w_next_state = MemWriteM ? StWrite : StIssue;
        end
      end
      StWrite: w_next_state = StIdle;
      StIssue: begin
        w_busy       = 1'b1;
        w_next_state = StWait;
      end
      StWait: begin
        w_busy = 1'b1;
        if (r_cnt == CNT_W'(MEM_LAT)) begin
          w_capture    = 1'b1;
          w_next_state = StDone;
        end
      end
      StDone:  w_next_state = StIdle;
      default: w_next_state = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_rden     <= 1'b0;
      r_wren     <= 1'b0;
      r_addr     <= '0;
      r_byteena  <= '0;
      r_wdata    <= '0;
      r_misalign <= 1'b0;
      r_vec      <= 1'b0;
      r_lane     <= '0;
      r_rdata_s  <= '0;
      r_rdata_v  <= '0;
    end else begin
      r_state <= w_next_state;

      if (r_state == StIssue) begin
        r_cnt <= CNT_W'(1);
      end else if (r_state == StWait) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end

      // Strobe-side registers are loaded only on accept, so they are live
      // exactly for the WRITE/ISSUE cycle that follows and zero otherwise.
      r_rden     <= w_accept & ~MemWriteM;
      r_wren     <= w_accept & MemWriteM;
      r_addr     <= w_accept ? w_line_addr : '0;
      r_byteena  <= w_accept ? w_byteena : '0;
      r_wdata    <= (w_accept & MemWriteM) ? w_wline : '0;
      r_misalign <= w_accept & w_misalign;

      if (w_accept) begin
        r_vec  <= VecDataM;
        r_lane <= VecDataM ? '0 : w_lane;
      end

      if (w_capture) begin
        r_rdata_s <= w_rscalar;
        if (r_vec) begin
          r_rdata_v <= ReadData;
        end
      end
    end
  end

  assign RdenData    = r_rden;
  assign WrenData    = r_wren;
  assign AddressData = r_addr;
  assign ByteenaData = r_byteena;
  assign WriteData   = r_wdata;
  assign ReadDataM   = r_rdata_s;
  assign ReadDataVM  = r_rdata_v;
  assign BusyDA      = w_busy;
  assign MisalignM   = r_misalign;

endmodule

// File: tb/tb_data_aligner.sv
// Scoreboard bench for data_aligner with a behavioural memory and reference model.
module tb_data_aligner;

  localparam int unsigned MEM_LAT = 2;

  logic         clk;
  logic         rst;
  logic         en;
  logic         MemtoRegM;
  logic         MemWriteM;
  logic         VecDataM;
  logic [31:0]  ALUResultM;
  logic [31:0]  WriteDataM;
  logic [255:0] WriteDataVM;
  logic [255:0] ReadData;
  logic         RdenData;
  logic         WrenData;
  logic [31:0]  AddressData;
  logic [31:0]  ByteenaData;
  logic [255:0] WriteData;
  logic [31:0]  ReadDataM;
  logic [255:0] ReadDataVM;
  logic         BusyDA;
  logic         MisalignM;

  data_aligner #(
    .N       (32),
    .V       (256),
    .MEM_LAT (MEM_LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .MemtoRegM   (MemtoRegM),
    .MemWriteM   (MemWriteM),
    .VecDataM    (VecDataM),
    .ALUResultM  (ALUResultM),
    .WriteDataM  (WriteDataM),
    .WriteDataVM (WriteDataVM),
    .ReadData    (ReadData),
    .RdenData    (RdenData),
    .WrenData    (WrenData),
    .AddressData (AddressData),
    .ByteenaData (ByteenaData),
    .WriteData   (WriteData),
    .ReadDataM   (ReadDataM),
    .ReadDataVM  (ReadDataVM),
    .BusyDA      (BusyDA),
    .MisalignM   (MisalignM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [31:0]  be;
    logic [255:0] wd;
    bit           mis;
  } strobe_t;

  typedef struct {
    logic [31:0]  rdm;
    logic [255:0] rdvm;
  } load_t;

  strobe_t      sq[$];
  load_t        lq[$];
  logic [255:0] mem     [16];  // memory seen by the DUT, written through its strobes
  logic [255:0] ref_mem [16];  // reference contents, updated from request semantics
  logic [255:0] m_rdvm;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic check_zero(input string name);
    chk({name, "_ctl"}, 256'({RdenData, WrenData, BusyDA, MisalignM, AddressData, ByteenaData,
                              ReadDataM}), '0);
    chk({name, "_wdata"}, WriteData, '0);
    chk({name, "_rdvm"}, ReadDataVM, '0);
  endtask

  // Memory responder: writes apply byte enables; reads return the line MEM_LAT cycles later.
  always @(negedge clk) begin
    if (rst && WrenData) begin
      for (int b = 0; b < 32; b++)
        if (ByteenaData[b]) mem[AddressData[3:0]][8*b +: 8] = WriteData[8*b +: 8];
    end
  end

  always @(negedge clk) begin
    logic [3:0] a;
    if (rst && RdenData) begin
      a = AddressData[3:0];
      repeat (MEM_LAT) @(posedge clk);
      #1 ReadData = mem[a];
      @(posedge clk);
      #1 ReadData = rand256();
    end
  end

  // Monitor
  bit           inflight = 1'b0;
  int           lat = 0;
  logic [31:0]  mon_rdm = '0;
  logic [255:0] mon_rdvm = '0;
  strobe_t      ms;
  load_t        ml;

  always @(negedge clk) begin
    if (!rst) begin
      inflight = 1'b0;
      mon_rdm  = '0;
      mon_rdvm = '0;
    end else begin
      if (inflight) begin
        lat++;
        if (!BusyDA) begin
          chk("load_latency", 256'(lat), 256'(MEM_LAT + 1));
          if (lq.size() == 0) chk("load_expected", 256'(lq.size()), 256'(1));
          else begin
            ml = lq.pop_front();
            mon_rdm  = ml.rdm;
            mon_rdvm = ml.rdvm;
          end
          inflight = 1'b0;
        end else if (lat > 30) begin
          chk("load_timeout", 256'(lat), 256'(MEM_LAT + 1));
          inflight = 1'b0;
        end
      end
      if (!inflight) begin
        chk("ReadDataM", 256'(ReadDataM), 256'(mon_rdm));
        chk("ReadDataVM", ReadDataVM, mon_rdvm);
      end
      if (WrenData || RdenData) begin
        chk("strobe_exclusive", 256'(WrenData & RdenData), '0);
        if (sq.size() == 0) chk("strobe_expected", 256'(sq.size()), 256'(1));
        else begin
          ms = sq.pop_front();
          chk("strobe_kind", 256'(WrenData), 256'(ms.wr));
          chk("line_addr", 256'(AddressData), 256'(ms.addr));
          chk("misalign", 256'(MisalignM), 256'(ms.mis));
          if (ms.wr) begin
            chk("byteena", 256'(ByteenaData), 256'(ms.be));
            chk("write_line", WriteData, ms.wd);
          end
        end
        if (RdenData) begin
          inflight = 1'b1;
          lat = 0;
        end
      end else begin
        chk("idle_addr_be_mis", 256'({AddressData, ByteenaData, MisalignM}), '0);
        chk("idle_wdata", WriteData, '0);
      end
    end
  end

  // Issue one request (called just after a rising edge); returns just after the
  // rising edge that ends the cycle in which the pipeline is released.
  task automatic do_req(input bit st, input bit ld, input bit vec, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [255:0] wdv);
    strobe_t s;
    load_t   l;
    int      lane;
    int      line;
    int      busy;
    int      exp_busy;
    lane   = int'((addr >> 2) % 8);
    line   = int'(addr / 32) % 16;
    s.wr   = st;
    s.addr = 32'(line);
    s.mis  = vec ? (addr % 32 != 0) : (addr % 4 != 0);
    s.be   = vec ? 32'hFFFF_FFFF : (32'hF << (4 * lane));
    s.wd   = st ? (vec ? wdv : {8{wd}}) : '0;
    sq.push_back(s);
    if (st) begin
      if (vec) ref_mem[line] = wdv;
      else ref_mem[line][32*lane +: 32] = wd;
      exp_busy = 1;
    end else begin
      if (vec) begin
        m_rdvm = ref_mem[line];
        l.rdm  = ref_mem[line][31:0];
      end else begin
        l.rdm  = ref_mem[line][32*lane +: 32];
      end
      l.rdvm = m_rdvm;
      lq.push_back(l);
      exp_busy = MEM_LAT + 2;
    end
    en          = 1'b1;
    MemWriteM   = st;
    MemtoRegM   = ld;
    VecDataM    = vec;
    ALUResultM  = addr;
    WriteDataM  = wd;
    WriteDataVM = wdv;
    busy = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!BusyDA) break;
      busy++;
    end
    chk("busy_cycles", 256'(busy), 256'(exp_busy));
    @(posedge clk);
    #1;
    MemWriteM   = 1'b0;
    MemtoRegM   = 1'b0;
    ALUResultM  = $urandom;
    WriteDataM  = $urandom;
    WriteDataVM = rand256();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    bit          v;
    int          op;
    rst = 1'b0; en = 1'b0; MemtoRegM = 1'b0; MemWriteM = 1'b0; VecDataM = 1'b0;
    ALUResultM = '0; WriteDataM = '0; WriteDataVM = '0; ReadData = rand256();
    m_rdvm = '0;
    for (int i = 0; i < 16; i++) begin
      mem[i]     = rand256();
      ref_mem[i] = mem[i];
    end
    mem[1][32*7 +: 32]     = 32'h1234_5678;
    ref_mem[1][32*7 +: 32] = 32'h1234_5678;

    #3 check_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases
    do_req(1'b1, 1'b0, 1'b0, 32'h48, 32'hDEAD_BEEF, '0);
    do_req(1'b0, 1'b1, 1'b0, 32'h3C, '0, '0);
    do_req(1'b1, 1'b0, 1'b1, 32'h40, '0, rand256());
    do_req(1'b0, 1'b1, 1'b1, 32'h40, '0, '0);
    do_req(1'b0, 1'b1, 1'b0, 32'h41, '0, '0);
    do_req(1'b1, 1'b0, 1'b1, 32'h50, '0, rand256());

    en = 1'b0; MemtoRegM = 1'b1; ALUResultM = 32'h20;
    repeat (4) begin
      @(negedge clk);
      chk("en_low_busy", 256'(BusyDA), '0);
    end
    @(posedge clk);
    #1 MemtoRegM = 1'b0; en = 1'b1;

    do_req(1'b1, 1'b0, 1'b0, 32'h84, $urandom, '0);
    do_req(1'b0, 1'b1, 1'b0, 32'h84, '0, '0);
    do_req(1'b1, 1'b1, 1'b0, 32'h88, $urandom, '0);
    do_req(1'b0, 1'b1, 1'b1, 32'h80, '0, '0);

    // Random traffic
    for (int n = 0; n < 80; n++) begin
      op = $urandom_range(0, 2);
      v  = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 511));
      if ($urandom_range(0, 1) == 1) a = v ? (a & ~32'd31) : (a & ~32'd3);
      do_req(op != 1, op != 0, v, a, $urandom, rand256());
      repeat ($urandom_range(0, 2)) begin
        en = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
      end
      en = 1'b1;
    end

    // Reset while the load is waiting on memory
    begin
      strobe_t s;
      s.wr = 1'b0; s.addr = 32'd3; s.be = '0; s.wd = '0; s.mis = 1'b0;
      sq.push_back(s);
      en = 1'b1; MemtoRegM = 1'b1; VecDataM = 1'b0; ALUResultM = 32'h64;
      @(negedge clk);
      @(posedge clk);
      #1 MemtoRegM = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      #1 check_zero("reset_mid_wait");
      m_rdvm = '0;
      @(negedge clk);
      #2 rst = 1'b1;
      repeat (4) begin
        @(negedge clk);
        chk("after_reset_busy", 256'(BusyDA), '0);
        chk("after_reset_rdm", 256'(ReadDataM), '0);
      end
      @(posedge clk);
      #1;
    end

    do_req(1'b0, 1'b1, 1'b0, 32'h3C, '0, '0);
    do_req(1'b0, 1'b1, 1'b1, 32'h40, '0, '0);

    repeat (5) @(negedge clk);
    chk("strobe_queue_drained", 256'(sq.size()), '0);
    chk("load_queue_drained", 256'(lq.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/data_aligner.md
Name: data_aligner

Overview:
Memory-stage access unit between register_EM outputs and the 256-bit data memory.
- Converts scalar (32-bit) and vector (256-bit) load/store requests into line-addressed memory accesses with byte enables.
- Extracts and aligns load data for the M/W pipeline register.
- Drives BusyDA to the hazard unit while a multi-cycle access is in flight.

Parameters:
- N, 32, scalar data/address width.
- V, 256, vector and memory line width; one line = V/8 bytes.
- MEM_LAT, 2, cycles from the cycle RdenData is high to the cycle ReadData is valid; legal range 1..7.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- en  in  1  when low, no new request is accepted; in-flight accesses still complete
- MemtoRegM  in  1  load request
- MemWriteM  in  1  store request
- VecDataM  in  1  1 = vector access, 0 = scalar access
- ALUResultM  in  N  byte address
- WriteDataM  in  N  scalar store data
- WriteDataVM  in  V  vector store data
- ReadData  in  V  memory read line
- RdenData  out  1  memory read strobe
- WrenData  out  1  memory write strobe
- AddressData  out  N  line address
- ByteenaData  out  N  byte enables, one per line byte
- WriteData  out  V  memory write line
- ReadDataM  out  N  aligned scalar load result
- ReadDataVM  out  V  vector load result
- BusyDA  out  1  stall request to the hazard unit; combinational
- MisalignM  out  1  one-cycle misalignment flag

Behaviour:
- Reset: state IDLE, latency counter 0; every output listed above is 0, including ReadDataM and ReadDataVM.
- FSM states: IDLE, WRITE, ISSUE, WAIT, DONE.
- Accept: in IDLE with en=1 and (MemtoRegM | MemWriteM). BusyDA=1 in the accept cycle. Address, VecDataM and data are captured on the edge.
- Both MemWriteM and MemtoRegM high: the request is treated as a store.
- Store: IDLE -> WRITE. WRITE lasts one cycle with WrenData=1 and BusyDA=0, so the pipeline advances; next state IDLE. Requests are never accepted in WRITE, DONE or ISSUE.
- Load: IDLE -> ISSUE. ISSUE drives RdenData=1 for one cycle, then moves to WAIT with counter=1.
- WAIT: counter increments each cycle. When counter==MEM_LAT, ReadData is captured into ReadDataM/ReadDataVM and the FSM moves to DONE.
- DONE: BusyDA=0 for one cycle with the results valid; next state IDLE.
- BusyDA is 1 in accept, ISSUE and WAIT. A load therefore stalls for MEM_LAT+2 cycles.
- ReadDataM and ReadDataVM hold their value until the next load capture.
- AddressData = {5'b0, addr[N-1:5]}; AddressData is held during strobes only and is 0 otherwise.
- Scalar lane = addr[4:2].
  - Store: ByteenaData = 32'hF << (4*lane); WriteData = WriteDataM replicated 8 times.
  - Load: ReadDataM = ReadData[32*lane +: 32]; ReadDataVM unchanged.
- Vector:
  - Store: ByteenaData = all ones; WriteData = WriteDataVM.
  - Load: ReadDataVM = ReadData; ReadDataM = ReadData[31:0].
- Misalignment: scalar with addr[1:0]!=0, or vector with addr[4:0]!=0.
  - MisalignM pulses in the cycle after accept (registered).
  - The access still proceeds with the offending low bits ignored.
- Memory strobes, ByteenaData and WriteData are registered and are 0 outside WRITE/ISSUE.
- en=0 during ISSUE/WAIT has no effect; the access completes.
- Reset mid-access: immediate return to IDLE; a late ReadData return is ignored, and no capture or DONE occurs.
- Timing: no combinational path from ReadData to BusyDA.

Decomposition:
- Package aligner_pkg holds:
  - state enum da_state_t
  - LINE_BYTES = V/8
  - OFFSET_BITS = 5
  - LANE_BITS = 3
  - MEM_LAT counter width = 3
- Sub-module lane_mapper (combinational) holds all width and shift rules:
  - lane select
  - byte-enable generation
  - scalar replication
  - scalar extract
- data_aligner holds the FSM, capture registers and strobes.

Test Plan:
- Scalar store: addr=0x0000_0048, WriteDataM=0xDEADBEEF, VecDataM=0 -> 1 busy cycle, then WrenData=1, AddressData=2, ByteenaData=0x0000_0F00, WriteData lane2=0xDEADBEEF; MisalignM=0.
- Scalar load, MEM_LAT=2: addr=0x3C, memory line lane7=0x12345678 -> RdenData in cycle t+1, BusyDA high t..t+3, DONE at t+4 with ReadDataM=0x12345678.
- Vector load/store at 0x40: pattern line written with ByteenaData=0xFFFFFFFF -> read back gives ReadDataVM equal to the written pattern.
- Misaligned: scalar addr=0x41 -> MisalignM=1 for one cycle; access uses lane 0 of line 2.
- Vector addr=0x50 -> MisalignM=1 for one cycle.
- en=0 with MemtoRegM=1 -> no strobe, BusyDA=0. Back-to-back store then load -> correct ordering, no double accept.
- rst asserted during WAIT -> all outputs 0 immediately; a ReadData return afterwards leaves ReadDataM=0 and the FSM in IDLE.
